// File: rtl/sonic_tx_data_ring_128_64_pkg.sv
// Shared constants and types for the 128-to-64 transmit data ring.
package sonic_tx_data_ring_128_64_pkg;

  localparam int TX_READ_ADDR_WIDTH  = 10;
  localparam int TX_WRITE_ADDR_WIDTH = TX_READ_ADDR_WIDTH - 1;
  localparam int LANE_WIDTH          = 32;
  localparam int LANE_COUNT          = 4;

  typedef logic [TX_READ_ADDR_WIDTH:0] tx_ring_level_t;

endpackage

// File: rtl/sonic_tx_data_ring_128_64_if.sv
// Host-side write and PHY-side read handshakes of the transmit data ring.
interface sonic_tx_data_ring_128_64_if
  import sonic_tx_data_ring_128_64_pkg::*;
#(
  parameter int RD_ADDR_WIDTH = TX_READ_ADDR_WIDTH
);

  logic [127:0]           wr_data;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [63:0]            rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [RD_ADDR_WIDTH:0] rd_level;

  modport master (
    output wr_data, wr_valid, rd_ready,
    input  wr_ready, rd_data, rd_valid, rd_level
  );

  modport slave (
    input  wr_data, wr_valid, rd_ready,
    output wr_ready, rd_data, rd_valid, rd_level
  );

endinterface

// File: rtl/sonic_tx_data_ring_128_64_bank.sv
// One 32-bit lane of ring storage: simple dual-port RAM with a registered,
// read-enabled output that holds its value while rden is low.
module sonic_tx_ring_bank
  import sonic_tx_data_ring_128_64_pkg::*;
#(
  parameter int ADDR_WIDTH = TX_WRITE_ADDR_WIDTH,
  parameter int DATA_WIDTH = LANE_WIDTH
) (
  input  logic                  clock,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddr,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddr,
  output logic [DATA_WIDTH-1:0] rddata
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wren) mem[wraddr] <= wrdata;
    if (rden) rddata <= mem[rdaddr];
  end

endmodule

// File: rtl/sonic_tx_data_ring_128_64.sv
// Transmit ring: 128-bit host writes in, 64-bit words out, low half first,
// with a two-entry prefetch skid (bank output register + output register).
module sonic_tx_data_ring_128_64
  import sonic_tx_data_ring_128_64_pkg::*;
#(
  parameter int RD_ADDR_WIDTH = TX_READ_ADDR_WIDTH
) (
  input logic clock,
  input logic reset_n,
  input logic flush,
  sonic_tx_data_ring_128_64_if.slave bus
);

  localparam int WR_ADDR_WIDTH = RD_ADDR_WIDTH - 1;
  localparam int DEPTH         = 1 << RD_ADDR_WIDTH;

  typedef logic [RD_ADDR_WIDTH:0] level_t;

  localparam level_t LEVEL_WR_MAX = level_t'(DEPTH - 2);

  logic [WR_ADDR_WIDTH-1:0] wptr;
  logic [RD_ADDR_WIDTH-1:0] rptr;
  level_t                   level;
  level_t                   unfetched;
  logic                     s1_valid;
  logic                     s1_hi;
  logic [63:0]              s1_data;
  logic                     out_valid;
  logic [63:0]              out_data;
  logic [LANE_WIDTH-1:0]    bank_q [LANE_COUNT];
  logic                     wr_accept;
  logic                     rd_accept;
  logic                     out_load;
  logic                     fetch;

  assign bus.wr_ready = (level <= LEVEL_WR_MAX) && !flush && reset_n;
  assign bus.rd_data  = out_data;
  assign bus.rd_valid = out_valid;
  assign bus.rd_level = level;

  assign wr_accept = bus.wr_valid && bus.wr_ready;
  assign rd_accept = out_valid && bus.rd_ready;
  assign out_load  = s1_valid && (!out_valid || bus.rd_ready);

  // Words in the skid are still counted by level, so what remains is in RAM.
  assign unfetched = level - level_t'(s1_valid) - level_t'(out_valid);
  assign fetch     = (unfetched != '0) && (!s1_valid || out_load) && !flush && reset_n;

  assign s1_data = s1_hi ? {bank_q[3], bank_q[2]} : {bank_q[1], bank_q[0]};

  for (genvar g = 0; g < LANE_COUNT; g++) begin : g_bank
    sonic_tx_ring_bank #(
      .ADDR_WIDTH(WR_ADDR_WIDTH),
      .DATA_WIDTH(LANE_WIDTH)
    ) u_bank (
      .clock  (clock),
      .wren   (wr_accept),
      .wraddr (wptr),
      .wrdata (bus.wr_data[g*LANE_WIDTH +: LANE_WIDTH]),
      .rden   (fetch),
      .rdaddr (rptr[RD_ADDR_WIDTH-1:1]),
      .rddata (bank_q[g])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      s1_valid  <= 1'b0;
      s1_hi     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      s1_valid  <= 1'b0;
      s1_hi     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (wr_accept) wptr <= wptr + 1'b1;
      if (fetch) begin
        rptr  <= rptr + 1'b1;
        s1_hi <= rptr[0];
      end
      if (fetch) s1_valid <= 1'b1;
      else if (out_load) s1_valid <= 1'b0;
      if (out_load) begin
        out_data  <= s1_data;
        out_valid <= 1'b1;
      end else if (rd_accept) begin
        out_valid <= 1'b0;
      end
      level <= level + level_t'({wr_accept, 1'b0}) - level_t'(rd_accept);
    end
  end

endmodule

// File: doc/sonic_tx_data_ring_128_64.md
Name: sonic_tx_data_ring_128_64

Overview:
- Single-clock transmit-side data ring buffer.
- Accepts 128-bit words from the host/DMA side and emits them as 64-bit words toward the TX encoder/PHY side.
- Storage is split into four 32-bit banks for resource efficiency.
- Valid/ready handshakes on both sides, occupancy reporting and a synchronous flush.

Parameters:
- RD_ADDR_WIDTH, 10, log2 of ring depth in 64-bit words (DEPTH = 2^RD_ADDR_WIDTH = 1024).
- WR_ADDR_WIDTH, RD_ADDR_WIDTH-1, log2 of ring depth in 128-bit words (derived, not overridable).

Ports:
- clock  in  1  sole clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous ring clear.
- wr_data  in  128  write word; bits [63:0] are emitted first, bits [127:64] second.
- wr_valid  in  1  write request.
- wr_ready  out  1  ring can accept one 128-bit word this cycle.
- rd_data  out  64  read word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer accepts rd_data this cycle.
- rd_level  out  RD_ADDR_WIDTH+1  64-bit words held (written, not yet consumed).

Behaviour:
- Reset (reset_n=0 at a clock edge): wr/rd pointers=0, rd_level=0, rd_valid=0, rd_data=0, wr_ready=0 while reset_n=0.
  - wr_ready=1 from the first cycle after release.
  - Reset mid-transfer discards all contents.
- Storage: banks 0..3, each 32b x 2^WR_ADDR_WIDTH.
  - A write at wptr stores wr_data[31:0]/[63:32]/[95:64]/[127:96] into banks 0/1/2/3 at address wptr. All four bank write enables are asserted together.
  - Read pointer rptr is in 64-bit units. rptr[0]=0 selects banks {1,0}; rptr[0]=1 selects banks {3,2}. The bank address is rptr[RD_ADDR_WIDTH-1:1].
- Write accept: wr_valid && wr_ready. Adds 2 to rd_level; wptr increments, wrapping at 2^WR_ADDR_WIDTH.
- wr_ready = (rd_level <= DEPTH-2) && !flush && reset_n. It is combinational from registered level.
- Read accept: rd_valid && rd_ready. Subtracts 1 from rd_level.
  - A slot is freed only on read accept, so prefetched data is never overwritten.
- Simultaneous write and read accept: rd_level += 1.
- Latency: a word accepted at edge N appears with rd_valid=1 after edge N+2 (high half after N+3) when the ring was empty and rd_ready=1.
  - The RAM read is registered. Prefetch is achieved with a 2-entry output skid (RAM data register plus output register).
- Throughput: with rd_ready held high and data available, one 64-bit word per cycle, no bubbles, including across pointer wrap.
- Backpressure: while rd_valid && !rd_ready, rd_data and rd_valid hold stable.
- Order: strict FIFO, low half before high half of each 128-bit word.
- Empty: rd_valid=0 and rd_data holds its last value. No underflow is possible.
- Full: rd_level=DEPTH, wr_ready=0. rd_level=DEPTH-1 also gives wr_ready=0, since 2 words are required.
- Flush: takes effect at the edge where flush=1.
  - Pointers, skid and rd_level are cleared; rd_valid=0 next cycle.
  - A concurrent write or read handshake is ignored: wr_ready is already forced 0, and a read accept in that cycle is discarded.
- rd_level is registered and reflects handshakes completed up to the previous edge.

Decomposition:
- Shared constants package:
  - TX_READ_ADDR_WIDTH and TX_WRITE_ADDR_WIDTH defaults.
  - Lane width (32) and lane count (4).
  - A tx_ring_level_t typedef.
- One natural sub-module, sonic_tx_ring_bank: single-clock 32-bit simple dual-port RAM with registered read and rden.
  - Four instances are used.
  - The pointer, level and skid logic stays in the top.

Test Plan:
- Reset release, then one write of 0x0123456789ABCDEF_FEDCBA9876543210 at edge N, rd_ready=1 -> rd_data=0xFEDCBA9876543210 valid after N+2, 0x0123456789ABCDEF after N+3; rd_level sequence 2,1,0.
- rd_ready=0, 512 back-to-back writes -> all accepted, rd_level=1024, wr_ready=0; the 513th write stalls until two reads complete (rd_level 1022 -> wr_ready=1).
- Write 3000 incrementing 128-bit words with both sides streaming -> 6000 64-bit outputs, correct order through multiple wraps, no bubbles once started.
- Random rd_ready toggling (50%) with random wr_valid -> rd_data stable whenever stalled; scoreboard match; rd_level never exceeds 1024.
- Level 1023 with simultaneous read and write request -> write not accepted, read accepted, rd_level=1022 next cycle, wr_ready=1.
- flush asserted with 100 words queued and rd_valid=1 -> rd_valid=0 and rd_level=0 next cycle; the next write's low half is the first word read out.
